// File: rtl/sc_game_status_monitor.sv
// sc_game_status_monitor
// Frogger game-status monitor. Follows the main FSM state code, tracks
// lives, score and the per-life countdown while the game is running, and
// sends the active-low end-game request back to the main FSM. It also
// pulses a frog-respawn request for the frog position logic.
//
// Ports
//   SC_MAIN_STATEMACHINE_CLOCK_50      in   system clock
//   SC_MAIN_STATEMACHINE_RESET_InHigh  in   async reset, active high
//   SC_GAME_STATUS_CurrentState_In     in   00 await, 01 play, 10 ended, 11 = 00
//   SC_GAME_STATUS_Collision_In        in   pulse: frog hit an obstacle
//   SC_GAME_STATUS_Goal_In             in   pulse: frog reached home row
//   SC_GAME_STATUS_Tick_In             in   pulse: countdown timebase
//   SC_GAME_STATUS_EndGame_OutLow      out  end-game request (low = end)
//   SC_GAME_STATUS_Respawn_Out         out  pulse: return frog to start
//   SC_GAME_STATUS_Win_Out             out  game ended by reaching WIN_SCORE
//   SC_GAME_STATUS_Lives_Out           out  remaining lives
//   SC_GAME_STATUS_Score_Out           out  goals scored
//   SC_GAME_STATUS_TimeLeft_Out        out  remaining ticks for this life
module sc_game_status_monitor #(
  parameter int LIVES_INIT  = 3,
  parameter int LIVES_WIDTH = 2,
  parameter int WIN_SCORE   = 5,
  parameter int SCORE_WIDTH = 4,
  parameter int TIME_LIMIT  = 60,
  parameter int TIMER_WIDTH = 6
) (
  input  logic                   SC_MAIN_STATEMACHINE_CLOCK_50,
  input  logic                   SC_MAIN_STATEMACHINE_RESET_InHigh,
  input  logic [1:0]             SC_GAME_STATUS_CurrentState_In,
  input  logic                   SC_GAME_STATUS_Collision_In,
  input  logic                   SC_GAME_STATUS_Goal_In,
  input  logic                   SC_GAME_STATUS_Tick_In,
  output logic                   SC_GAME_STATUS_EndGame_OutLow,
  output logic                   SC_GAME_STATUS_Respawn_Out,
  output logic                   SC_GAME_STATUS_Win_Out,
  output logic [LIVES_WIDTH-1:0] SC_GAME_STATUS_Lives_Out,
  output logic [SCORE_WIDTH-1:0] SC_GAME_STATUS_Score_Out,
  output logic [TIMER_WIDTH-1:0] SC_GAME_STATUS_TimeLeft_Out
);

  localparam logic [LIVES_WIDTH-1:0] LIVES_LD = LIVES_WIDTH'(LIVES_INIT);
  localparam logic [SCORE_WIDTH-1:0] SCORE_WN = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [TIMER_WIDTH-1:0] TIME_LD  = TIMER_WIDTH'(TIME_LIMIT);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t                 r_state;
  logic [LIVES_WIDTH-1:0] r_lives;
  logic [SCORE_WIDTH-1:0] r_score;
  logic [TIMER_WIDTH-1:0] r_time;
  logic                   r_endgame_n;
  logic                   r_respawn;
  logic                   r_win;

  // State codes 00 and 11 both mean "await".
  logic                   w_cs_play;
  logic                   w_cs_ended;
  logic                   w_cs_await;
  logic                   w_life_lost;
  logic [SCORE_WIDTH-1:0] w_score_inc;

  assign w_cs_play   = (SC_GAME_STATUS_CurrentState_In == 2'b01);
  assign w_cs_ended  = (SC_GAME_STATUS_CurrentState_In == 2'b10);
  assign w_cs_await  = !w_cs_play && !w_cs_ended;
  // Running out of time costs a life exactly like a collision does.
  assign w_life_lost = SC_GAME_STATUS_Collision_In ||
                       (SC_GAME_STATUS_Tick_In && (r_time == TIMER_WIDTH'(1)));
  assign w_score_inc = r_score + SCORE_WIDTH'(1);

  always_ff @(posedge SC_MAIN_STATEMACHINE_CLOCK_50 or
              posedge SC_MAIN_STATEMACHINE_RESET_InHigh) begin
    if (SC_MAIN_STATEMACHINE_RESET_InHigh) begin
      r_state     <= IDLE;
      r_lives     <= LIVES_LD;
      r_score     <= '0;
      r_time      <= TIME_LD;
      r_endgame_n <= 1'b1;
      r_respawn   <= 1'b0;
      r_win       <= 1'b0;
    end else begin
      r_respawn <= 1'b0;
      case (r_state)
        IDLE: begin
          // Hold the start-of-game values; events are ignored here.
          r_lives     <= LIVES_LD;
          r_score     <= '0;
          r_time      <= TIME_LD;
          r_win       <= 1'b0;
          r_endgame_n <= 1'b1;
          if (w_cs_play) r_state <= RUN;
        end
        RUN: begin
          if (w_cs_await) begin
            r_state <= IDLE;
            r_lives <= LIVES_LD;
            r_score <= '0;
            r_time  <= TIME_LD;
            r_win   <= 1'b0;
          end else if (w_life_lost) begin
            // Any goal or tick in the same cycle is dropped.
            if (r_lives == LIVES_WIDTH'(1)) begin
              r_lives     <= '0;
              r_win       <= 1'b0;
              r_state     <= OVER;
              r_endgame_n <= 1'b0;
            end else begin
              r_lives   <= r_lives - LIVES_WIDTH'(1);
              r_time    <= TIME_LD;
              r_respawn <= 1'b1;
            end
          end else if (SC_GAME_STATUS_Goal_In) begin
            r_score <= w_score_inc;
            if (w_score_inc == SCORE_WN) begin
              r_win       <= 1'b1;
              r_state     <= OVER;
              r_endgame_n <= 1'b0;
            end else begin
              r_time    <= TIME_LD;
              r_respawn <= 1'b1;
            end
          end else if (SC_GAME_STATUS_Tick_In) begin
            // TimeLeft == 1 with a tick was handled as a lost life above.
            r_time <= r_time - TIMER_WIDTH'(1);
          end else if (w_cs_ended) begin
            r_state     <= OVER;
            r_endgame_n <= 1'b0;
          end
        end
        OVER: begin
          // Everything frozen; end-game held low for a stable level.
          if (w_cs_await) begin
            r_state     <= IDLE;
            r_lives     <= LIVES_LD;
            r_score     <= '0;
            r_time      <= TIME_LD;
            r_win       <= 1'b0;
            r_endgame_n <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_endgame_n <= 1'b1;
        end
      endcase
    end
  end

  assign SC_GAME_STATUS_EndGame_OutLow = r_endgame_n;
  assign SC_GAME_STATUS_Respawn_Out    = r_respawn;
  assign SC_GAME_STATUS_Win_Out        = r_win;
  assign SC_GAME_STATUS_Lives_Out      = r_lives;
  assign SC_GAME_STATUS_Score_Out      = r_score;
  assign SC_GAME_STATUS_TimeLeft_Out   = r_time;

endmodule

// File: tb/tb_sc_game_status_monitor.sv
// Bench for sc_game_status_monitor: directed scenarios followed by a
// randomized run, all checked against a game-rules reference model.
module tb_sc_game_status_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cs;
  logic       col, goal, tick;
  logic       endg_n, resp, win;
  logic [1:0] lives;
  logic [3:0] score;
  logic [5:0] tleft;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  sc_game_status_monitor dut (
    .SC_MAIN_STATEMACHINE_CLOCK_50     (clk),
    .SC_MAIN_STATEMACHINE_RESET_InHigh (rst),
    .SC_GAME_STATUS_CurrentState_In    (cs),
    .SC_GAME_STATUS_Collision_In       (col),
    .SC_GAME_STATUS_Goal_In            (goal),
    .SC_GAME_STATUS_Tick_In            (tick),
    .SC_GAME_STATUS_EndGame_OutLow     (endg_n),
    .SC_GAME_STATUS_Respawn_Out        (resp),
    .SC_GAME_STATUS_Win_Out            (win),
    .SC_GAME_STATUS_Lives_Out          (lives),
    .SC_GAME_STATUS_Score_Out          (score),
    .SC_GAME_STATUS_TimeLeft_Out       (tleft)
  );

  // Reference model: game phase plus plain integer counters.
  bit playing, finished;
  int m_lives, m_score, m_time, m_win, m_resp;

  function automatic void m_init();
    m_lives = 3; m_score = 0; m_time = 60; m_win = 0; m_resp = 0;
  endfunction

  function automatic void m_reset();
    playing = 0; finished = 0; m_init();
  endfunction

  function automatic void m_clock(input logic [1:0] c, input logic co, input logic g, input logic t);
    bit await_code;
    await_code = (c == 2'b00) || (c == 2'b11);
    m_resp = 0;
    if (!playing && !finished) begin
      m_init();
      if (c == 2'b01) playing = 1;
    end else if (finished) begin
      if (await_code) begin finished = 0; m_init(); end
    end else if (await_code) begin
      playing = 0; m_init();
    end else if (co || (t && m_time == 1)) begin
      m_lives--;
      if (m_lives == 0) begin m_win = 0; playing = 0; finished = 1; end
      else begin m_time = 60; m_resp = 1; end
    end else if (g) begin
      m_score++;
      if (m_score == 5) begin m_win = 1; playing = 0; finished = 1; end
      else begin m_time = 60; m_resp = 1; end
    end else if (t) begin
      m_time--;
    end else if (c == 2'b10) begin
      playing = 0; finished = 1;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".lives"}, 32'(lives), 32'(m_lives));
    check({tag, ".score"}, 32'(score), 32'(m_score));
    check({tag, ".time"},  32'(tleft), 32'(m_time));
    check({tag, ".win"},   32'(win),   32'(m_win));
    check({tag, ".resp"},  32'(resp),  32'(m_resp));
    check({tag, ".endn"},  32'(endg_n), finished ? 32'd0 : 32'd1);
  endtask

  // Drive one cycle of inputs, clock it, then check after the edge.
  task automatic step(input string tag, input logic [1:0] c, input logic co,
                      input logic g, input logic t);
    cs = c; col = co; goal = g; tick = t;
    @(posedge clk);
    m_clock(c, co, g, t);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; cs = 0; col = 0; goal = 0; tick = 0;
    #3;
    m_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    do_reset();
    check_all("reset");

    // Reset defaults, events ignored while awaiting
    step("idle_col", 2'b00, 1, 0, 0);
    step("idle_goal", 2'b00, 0, 1, 1);
    check("idle_lives_const", 32'(lives), 32'd3);
    check("idle_time_const", 32'(tleft), 32'd60);

    // Lose all lives; events on the IDLE->RUN cycle are ignored
    step("start_col", 2'b01, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step("lose_col", 2'b01, 1, 0, 0);
      for (int j = 0; j < 9; j++) step("lose_gap", 2'b01, 0, 0, 0);
    end
    check("lose_endn", 32'(endg_n), 32'd0);
    check("lose_lives", 32'(lives), 32'd0);
    step("lose_frozen", 2'b10, 1, 1, 1);
    step("lose_abort", 2'b00, 0, 0, 0);
    check("lose_relives", 32'(lives), 32'd3);

    // Win with five goals, then frozen
    step("win_start", 2'b01, 0, 0, 0);
    for (int k = 0; k < 5; k++) step("win_goal", 2'b01, 0, 1, 0);
    check("win_flag", 32'(win), 32'd1);
    check("win_score", 32'(score), 32'd5);
    step("win_more", 2'b01, 0, 1, 0);
    step("win_more2", 2'b10, 0, 1, 0);
    step("win_idle", 2'b11, 0, 0, 0);

    // Timeout: 60 ticks cost one life
    step("to_start", 2'b01, 0, 0, 0);
    for (int k = 0; k < 60; k++) begin
      step("to_tick", 2'b01, 0, 0, 1);
      step("to_gap", 2'b01, 0, 0, 0);
    end
    check("to_lives", 32'(lives), 32'd2);
    check("to_time", 32'(tleft), 32'd60);

    // Simultaneous events: Lives=3 Score=2 TimeLeft=10
    step("sim_abort", 2'b00, 0, 0, 0);
    step("sim_start", 2'b01, 0, 0, 0);
    step("sim_g1", 2'b01, 0, 1, 0);
    step("sim_g2", 2'b01, 0, 1, 0);
    for (int k = 0; k < 50; k++) step("sim_tick", 2'b01, 0, 0, 1);
    check("sim_pre_time", 32'(tleft), 32'd10);
    step("sim_all", 2'b01, 1, 1, 1);
    check("sim_respawn", 32'(resp), 32'd1);

    // Main FSM ends on its own
    step("ext_end", 2'b10, 0, 0, 0);
    step("ext_hold", 2'b10, 0, 0, 1);

    // Abort mid-RUN
    step("ab_idle", 2'b00, 0, 0, 0);
    step("ab_start", 2'b01, 0, 0, 0);
    step("ab_goal", 2'b01, 0, 1, 0);
    step("ab_drop", 2'b00, 0, 0, 0);

    // Async reset between edges with Score = 3
    step("ar_start", 2'b01, 0, 0, 0);
    for (int k = 0; k < 3; k++) step("ar_goal", 2'b01, 0, 1, 0);
    step("ar_tick", 2'b01, 0, 0, 1);
    check("ar_pre_score", 32'(score), 32'd3);
    #3 rst = 1;
    #1;
    m_reset();
    check_all("ar_async");
    @(negedge clk);
    rst = 0;

    // Randomized play
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [1:0] c;
      r = int'($urandom_range(0, 99));
      c = (r < 90) ? 2'b01 : (r < 94) ? 2'b10 : (r < 97) ? 2'b00 : 2'b11;
      step("rand", c, ($urandom_range(0, 19) == 0), ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
